// File: rtl/axis_iic_arbiter_pkg.sv
// axis_iic_arbiter_pkg: shared FSM states, R/W bit position and round-robin helper.
package axis_iic_arbiter_pkg;
   typedef enum logic {ARB_ST, XFER_ST} state_t;
   localparam int RW_BIT = 0;
   // Returns {found, index} of the first requester strictly after ptr, wrapping at n.
   function automatic logic [4:0] rr_next(input logic [15:0] req, input logic [3:0] ptr, input int n);
      logic [4:0] win;
      int idx;
      win = '0;
      for (int k = 16; k >= 1; k--) begin
         idx = int'(ptr) + k;
         if (idx >= n) idx -= n;
         if (k <= n && req[idx[3:0]]) win = {1'b1, idx[3:0]};
      end
      return win;
   endfunction
endpackage

// File: rtl/axis_iic_tag_fifo.sv
// axis_iic_tag_fifo: synchronous FIFO of requester IDs awaiting read responses.
module axis_iic_tag_fifo #(
   parameter int W     = 2,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [W-1:0]             din,
   input  logic                     pop,
   output logic [W-1:0]             dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= din;
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   assign dout  = mem[rd_ptr];
   assign full  = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
endmodule

// File: rtl/axis_iic_arbiter.sv
// axis_iic_arbiter: packet round-robin arbiter in front of one axis_iic_bridge, routing read responses back by tag.
// Optional stall watchdog and timeout_pulse port enabled by AXIS_IIC_ARBITER_TIMEOUT_EN.
module axis_iic_arbiter
   import axis_iic_arbiter_pkg::*;
#(
   parameter int N_PORTS   = 4,
   parameter int N_BYTES   = 32,
   parameter int TAG_DEPTH = 8
`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
   , parameter int TIMEOUT_CYCLES = 65536
`endif
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [N_PORTS*N_BYTES*8-1:0]   s_req_tdata,
   input  logic [N_PORTS*N_BYTES-1:0]     s_req_tkeep,
   input  logic [N_PORTS*8-1:0]           s_req_tuser,
   input  logic [N_PORTS-1:0]             s_req_tvalid,
   input  logic [N_PORTS-1:0]             s_req_tlast,
   output logic [N_PORTS-1:0]             s_req_tready,
   output logic [N_BYTES*8-1:0]           m_cmd_tdata,
   output logic [N_BYTES-1:0]             m_cmd_tkeep,
   output logic [7:0]                     m_cmd_tuser,
   output logic                           m_cmd_tvalid,
   output logic                           m_cmd_tlast,
   input  logic                           m_cmd_tready,
   input  logic [N_BYTES*8-1:0]           s_rsp_tdata,
   input  logic [N_BYTES-1:0]             s_rsp_tkeep,
   input  logic [7:0]                     s_rsp_tuser,
   input  logic                           s_rsp_tvalid,
   input  logic                           s_rsp_tlast,
   output logic                           s_rsp_tready,
   output logic [N_BYTES*8-1:0]           m_rsp_tdata,
   output logic [N_BYTES-1:0]             m_rsp_tkeep,
   output logic [7:0]                     m_rsp_tuser,
   output logic                           m_rsp_tlast,
   output logic [N_PORTS-1:0]             m_rsp_tvalid,
   input  logic [N_PORTS-1:0]             m_rsp_tready,
   output logic [N_PORTS-1:0]             grant,
   output logic                           orphan_rsp
`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
   , output logic                         timeout_pulse
`endif
);
   localparam int DW = N_BYTES*8;
   localparam int PW = $clog2(N_PORTS);
   localparam int CW = $clog2(TAG_DEPTH)+1;
   state_t         state, nxt;
   logic [PW-1:0]  g, ptr, head;
   logic [4:0]     win;
   logic [CW-1:0]  tag_count;
   logic           first, acc, push, pop, rel, tmo, full, empty;
   assign win  = rr_next(16'(s_req_tvalid), 4'(ptr), N_PORTS);
   assign acc  = state == XFER_ST && s_req_tvalid[g] && m_cmd_tready;
   assign push = acc && first && s_req_tuser[int'(g)*8+RW_BIT];
   assign rel  = state == XFER_ST && ((acc && s_req_tlast[g]) || tmo);
   assign grant = state == XFER_ST ? N_PORTS'(1) << g : '0;
   assign m_cmd_tdata = s_req_tdata[int'(g)*DW +: DW];
   assign m_cmd_tkeep = s_req_tkeep[int'(g)*N_BYTES +: N_BYTES];
   assign m_cmd_tuser = s_req_tuser[int'(g)*8 +: 8];
   assign m_cmd_tlast = s_req_tlast[g];
   always_comb begin
      nxt          = state;
      m_cmd_tvalid = 1'b0;
      s_req_tready = '0;
      if (state == XFER_ST) begin
         m_cmd_tvalid    = s_req_tvalid[g];
         s_req_tready[g] = m_cmd_tready;
         if (rel) nxt = ARB_ST;
      end else if (win[4] && !full) nxt = XFER_ST;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ARB_ST;
         g     <= '0;
         ptr   <= PW'(N_PORTS-1);
         first <= 1'b0;
      end else begin
         state <= nxt;
         if (state == ARB_ST) begin
            g     <= win[PW-1:0];
            first <= 1'b1;
         end else if (acc) first <= 1'b0;
         if (rel) ptr <= g;
      end
   end
`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES)+1;
   logic [TW-1:0] cnt;
   assign tmo           = state == XFER_ST && !acc && cnt == TW'(TIMEOUT_CYCLES-1);
   assign timeout_pulse = tmo;
   always_ff @(posedge clk)
      cnt <= (reset || state == ARB_ST || acc) ? '0 : cnt + 1'b1;
`else
   assign tmo = 1'b0;
`endif
   axis_iic_tag_fifo #(.W(PW), .DEPTH(TAG_DEPTH)) u_tags (
      .clk(clk), .reset(reset), .push(push), .din(g), .pop(pop),
      .dout(head), .full(full), .empty(empty), .count(tag_count)
   );
   // Untagged responses are swallowed so a misbehaving bridge cannot stall the path.
   assign m_rsp_tdata  = s_rsp_tdata;
   assign m_rsp_tkeep  = s_rsp_tkeep;
   assign m_rsp_tuser  = s_rsp_tuser;
   assign m_rsp_tlast  = s_rsp_tlast;
   assign m_rsp_tvalid = (!reset && !empty) ? N_PORTS'(s_rsp_tvalid) << head : '0;
   assign s_rsp_tready = !reset && (empty || m_rsp_tready[head]);
   assign pop          = s_rsp_tvalid && s_rsp_tready && s_rsp_tlast && tag_count != '0;
   assign orphan_rsp   = !reset && empty && s_rsp_tvalid && s_rsp_tlast;
endmodule

// File: tb/tb_axis_iic_arbiter.sv
// tb_axis_iic_arbiter: directed self-checking bench for axis_iic_arbiter (N_PORTS=4, 1-byte beats).
module tb_axis_iic_arbiter;
   localparam int N = 4, NB = 1, DW = 8;
   logic clk = 0, reset = 1;
   logic [N*DW-1:0] req_data;
   logic [N*NB-1:0] req_keep;
   logic [N*8-1:0]  req_user;
   logic [N-1:0]    req_valid, req_last, req_ready;
   logic [DW-1:0]   cmd_data, rsp_data, mrsp_data;
   logic [NB-1:0]   cmd_keep, rsp_keep, mrsp_keep;
   logic [7:0]      cmd_user, rsp_user, mrsp_user;
   logic            cmd_valid, cmd_last, cmd_ready, rsp_valid, rsp_last, rsp_ready_o, mrsp_last, orphan;
   logic [N-1:0]    mrsp_valid, mrsp_ready, grant;
`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
   logic            tp;
`endif
   int checks = 0, errors = 0;
   always #5 clk = ~clk;

   axis_iic_arbiter #(.N_PORTS(N), .N_BYTES(NB), .TAG_DEPTH(8)
`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
      , .TIMEOUT_CYCLES(16)
`endif
   ) u_dut (
      .clk(clk), .reset(reset),
      .s_req_tdata(req_data), .s_req_tkeep(req_keep), .s_req_tuser(req_user),
      .s_req_tvalid(req_valid), .s_req_tlast(req_last), .s_req_tready(req_ready),
      .m_cmd_tdata(cmd_data), .m_cmd_tkeep(cmd_keep), .m_cmd_tuser(cmd_user),
      .m_cmd_tvalid(cmd_valid), .m_cmd_tlast(cmd_last), .m_cmd_tready(cmd_ready),
      .s_rsp_tdata(rsp_data), .s_rsp_tkeep(rsp_keep), .s_rsp_tuser(rsp_user),
      .s_rsp_tvalid(rsp_valid), .s_rsp_tlast(rsp_last), .s_rsp_tready(rsp_ready_o),
      .m_rsp_tdata(mrsp_data), .m_rsp_tkeep(mrsp_keep), .m_rsp_tuser(mrsp_user),
      .m_rsp_tlast(mrsp_last), .m_rsp_tvalid(mrsp_valid), .m_rsp_tready(mrsp_ready),
      .grant(grant), .orphan_rsp(orphan)
`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
      , .timeout_pulse(tp)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1;
      req_data = '0; req_keep = '1; req_user = '0; req_valid = '0; req_last = '0;
      cmd_ready = 1; rsp_data = '0; rsp_keep = '1; rsp_user = '0; rsp_valid = 0; rsp_last = 0;
      mrsp_ready = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 0;
   endtask

   task automatic send(input int p, input logic [7:0] u, input int n);
      int b = 0, t = 0;
      req_user[p*8 +: 8] = u;
      req_data[p*8 +: 8] = u;
      req_last[p] = n == 1;
      req_valid[p] = 1;
      while (b < n && t < 100) begin
         @(negedge clk);
         if (req_ready[p]) begin
            cyc();
            b++;
            req_last[p] = b == n-1;
            if (b == n) req_valid[p] = 0;
         end else t++;
      end
      check("send_done", b, n);
   endtask

   task automatic rsp(input int n, input logic [3:0] exp_v, input logic exp_orph);
      for (int b = 0; b < n; b++) begin
         rsp_valid = 1;
         rsp_last = b == n-1;
         rsp_data = 8'(8'h50 + b);
         @(negedge clk);
         check("rsp_route", mrsp_valid, exp_v);
         check("rsp_ready", rsp_ready_o, 1);
         check("orphan", orphan, exp_orph && b == n-1);
         cyc();
      end
      rsp_valid = 0;
      rsp_last = 0;
   endtask

   initial begin
      int cnt [N];
      logic [N-1:0] acc;
      int t;
      // reset state, sampled while reset is still held
      reset = 1;
      req_data = '0; req_keep = '1; req_user = '0; req_valid = '0; req_last = '0;
      cmd_ready = 1; rsp_data = '0; rsp_keep = '1; rsp_user = '0; rsp_valid = 0; rsp_last = 0;
      mrsp_ready = '1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_grant", grant, 0);
      check("rst_req_ready", req_ready, 0);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_rsp_ready", rsp_ready_o, 0);
      check("rst_orphan", orphan, 0);
      reset = 0;

      // two simultaneous 1-beat writes: port 0 then port 2
      req_valid = 4'b0101; req_last = 4'b0101;
      req_user[0 +: 8] = 8'hA0; req_user[16 +: 8] = 8'hA0;
      req_data[0 +: 8] = 8'h10; req_data[16 +: 8] = 8'h12;
      check("t1_idle", grant, 0);
      @(negedge clk);
      check("t1_g0", grant, 4'b0001);
      check("t1_user0", cmd_user, 8'hA0);
      check("t1_data0", cmd_data, 8'h10);
      check("t1_ready0", req_ready, 4'b0001);
      cyc();
      req_valid[0] = 0;
      @(negedge clk);
      check("t1_bubble", grant, 0);
      @(negedge clk);
      check("t1_g2", grant, 4'b0100);
      check("t1_user2", cmd_user, 8'hA0);
      check("t1_data2", cmd_data, 8'h12);
      cyc();
      req_valid[2] = 0;
      @(negedge clk);
      check("t1_done", grant, 0);

      // all ports continuously valid, 3-beat packets
      do_reset();
      for (int i = 0; i < N; i++) begin
         cnt[i] = 0;
         req_user[i*8 +: 8] = 8'(8'hB0 + i);
      end
      req_valid = '1; req_last = '0; acc = '0;
      for (int k = 0; k < 17; k++) begin
         cyc();
         for (int i = 0; i < N; i++) begin
            if (acc[i]) cnt[i] = cnt[i] == 2 ? 0 : cnt[i] + 1;
            req_last[i] = cnt[i] == 2;
         end
         @(negedge clk);
         check($sformatf("t2_grant%0d", k), grant, k % 4 == 3 ? 4'b0000 : 4'(1 << ((k / 4) % 4)));
         acc = req_ready & req_valid;
      end
      req_valid = '0;

      // reads from ports 1 and 3, responses routed back in order
      do_reset();
      send(1, 8'hA1, 1);
      send(3, 8'hA3, 1);
      rsp(2, 4'b0010, 0);
      rsp(2, 4'b1000, 0);
      mrsp_ready = '0;
      @(negedge clk);
      check("t3_fifo_empty", rsp_ready_o, 1);
      mrsp_ready = '1;

      // tag FIFO full blocks grants until a response completes
      do_reset();
      for (int i = 0; i < 8; i++) send(0, 8'hA1, 1);
      req_user[16 +: 8] = 8'hA0; req_last[2] = 1; req_valid[2] = 1;
      repeat (4) @(negedge clk);
      check("t4_full_block", grant, 0);
      cyc();
      rsp_valid = 1; rsp_last = 1;
      @(negedge clk);
      check("t4_pop_cycle", grant, 0);
      check("t4_route0", mrsp_valid, 4'b0001);
      cyc();
      rsp_valid = 0; rsp_last = 0;
      @(negedge clk);
      check("t4_after_pop", grant, 0);
      @(negedge clk);
      check("t4_granted", grant, 4'b0100);
      cyc();
      req_valid[2] = 0;

      // orphan response: swallowed, pulse only on the tlast beat
      do_reset();
      cyc();
      rsp(2, 4'b0000, 1);
      @(negedge clk);
      check("t5_orphan_off", orphan, 0);

      // reset in the middle of a 4-beat packet
      do_reset();
      req_user[8 +: 8] = 8'hB1; req_last[1] = 0; req_valid[1] = 1;
      t = 0;
      while (!req_ready[1] && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("t6_grant1", grant, 4'b0010);
      cyc();
      @(negedge clk);
      check("t6_mid_pkt", grant, 4'b0010);
      reset = 1;
      @(negedge clk);
      check("t6_rst_grant", grant, 0);
      check("t6_rst_ready", req_ready, 0);
      check("t6_rst_cmd_valid", cmd_valid, 0);
      reset = 0;
      req_user[0 +: 8] = 8'hB0; req_last[0] = 1; req_valid[0] = 1;
      @(negedge clk);
      check("t6_ptr_reset", grant, 4'b0001);
      cyc();
      req_valid = '0;

`ifdef AXIS_IIC_ARBITER_TIMEOUT_EN
      // stalled bridge: grant released after 16 cycles in transfer
      do_reset();
      cmd_ready = 0;
      req_user[16 +: 8] = 8'hA0; req_last[2] = 1; req_valid[2] = 1;
      t = 0;
      while (grant != 4'b0100 && t < 20) begin
         @(negedge clk);
         t++;
      end
      t = 0;
      while (!tp && t < 40) begin
         @(negedge clk);
         t++;
      end
      check("tmo_cycles", t, 15);
      check("tmo_grant_held", grant, 4'b0100);
      @(negedge clk);
      check("tmo_released", grant, 0);
      check("tmo_pulse_once", tp, 0);
      req_valid = '0;
      cmd_ready = 1;
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/axis_iic_arbiter.md
Name: axis_iic_arbiter

Overview:
- Packet-level round-robin arbiter sharing one axis_iic_bridge among N_PORTS command requesters.
- Forwards whole command packets (tuser = 8-bit I2C address + R/W bit in tuser[0]) to the bridge, one packet at a time.
- Records the requester ID of every read command, and routes each bridge response packet back to that requester in order.
- Sits between per-client AXIS masters and the single bridge instance.

Parameters:
- N_PORTS, 4, number of requesters (2..16).
- N_BYTES, 32, bytes per beat; DATA_WIDTH = N_BYTES*8.
- TAG_DEPTH, 8, max outstanding read commands (power of 2).
- TIMEOUT_CYCLES, 65536, stall watchdog limit (optional feature only).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_req_tdata/tkeep/tuser/tvalid/tlast  in  N_PORTS*DATA_WIDTH / N_PORTS*N_BYTES / N_PORTS*8 / N_PORTS / N_PORTS  requester command streams, port i in slice i.
- s_req_tready  out  N_PORTS  per-requester ready.
- m_cmd_tdata/tkeep/tuser/tvalid/tlast  out  DATA_WIDTH/N_BYTES/8/1/1  command stream to bridge.
- m_cmd_tready  in  1  bridge ready.
- s_rsp_tdata/tkeep/tuser/tvalid/tlast  in  DATA_WIDTH/N_BYTES/8/1/1  response stream from bridge.
- s_rsp_tready  out  1  response ready.
- m_rsp_tdata/tkeep/tuser/tlast  out  DATA_WIDTH/N_BYTES/8/1  response broadcast data to all requesters.
- m_rsp_tvalid  out  N_PORTS  per-requester response valid.
- m_rsp_tready  in  N_PORTS  per-requester response ready.
- grant  out  N_PORTS  one-hot current owner, 0 when idle.
- orphan_rsp  out  1  one-cycle pulse: response dropped, no tag.

Behaviour:
- Reset:
  - State ARB_ST; grant = 0; all tready and tvalid = 0.
  - Round-robin pointer = N_PORTS-1, so port 0 wins first.
  - Tag FIFO emptied; orphan_rsp = 0.
  - Reset mid-packet aborts the grant immediately; the partial packet is not completed.
- FSM ARB_ST:
  - Requesters are any with s_req_tvalid=1.
  - Winner = first requester strictly after the pointer, wrapping.
  - If the tag FIFO is full, no grant is issued until it is not full (reads and writes alike).
  - On a winner: grant registered next cycle, go XFER_ST.
  - Arbitration latency: 1 cycle from valid to grant.
- FSM XFER_ST:
  - Command path is a combinational mux of the granted port: m_cmd_* = s_req_*[g]; s_req_tready[g] = m_cmd_tready; other tready = 0.
  - On the first accepted beat, if tuser[0]=1 (read), push g into the tag FIFO.
  - On an accepted beat with tlast=1: pointer <= g, grant <= 0, go ARB_ST. The next packet is granted at the earliest 1 cycle later (one bubble per packet).
- Response path (independent of the FSM):
  - Tag FIFO not empty: head tag h; m_rsp_tvalid[h] = s_rsp_tvalid; s_rsp_tready = m_rsp_tready[h].
  - Accepted beat with tlast pops the tag.
  - Tag FIFO empty and s_rsp_tvalid: s_rsp_tready=1 and the beat is dropped. orphan_rsp pulses on each dropped tlast beat.
- Simultaneous push and pop in one cycle are both honoured; the count is unchanged. Push never occurs when full, guaranteed by the ARB gating.
- A single requester holding valid continuously gets back-to-back packets separated by one bubble.

Optional Feature:
- Macro: AXIS_IIC_ARBITER_TIMEOUT_EN.
- With the macro: a counter runs in XFER_ST and clears on each accepted command beat.
  - At TIMEOUT_CYCLES-1 it forces grant=0 and returns to ARB_ST, pointer <= g.
  - Output timeout_pulse (1 bit) pulses for one cycle.
  - A tag already pushed for the aborted packet stays in the FIFO.
- Without the macro: no counter, no timeout_pulse port; the grant is held until tlast indefinitely.

Decomposition:
- Package axis_iic_arbiter_pkg:
  - state enum {ARB_ST, XFER_ST};
  - localparam RW_BIT = 0;
  - function for round-robin next-index.
- Sub-module axis_iic_tag_fifo: sync FIFO, width $clog2(N_PORTS), depth TAG_DEPTH, with full/empty/count.

Test Plan:
- Ports 0 and 2 each present a 1-beat write (tuser=0xA0) at the same time → port 0 is granted first, then port 2; m_cmd shows 0xA0 twice; grant sequence 0001, 0000, 0100.
- Ports 0–3 all continuously valid, 3-beat packets → grant order 0,1,2,3,0; each packet takes 3 beats plus 1 bubble.
- Port 1 read (tuser=0xA1) then port 3 read (0xA3); bridge returns two 2-beat responses → first response is routed only to m_rsp_tvalid[1], second only to [3]; the tag FIFO ends empty.
- TAG_DEPTH=8: 8 reads outstanding with no responses, then a 9th request → no grant until one response tlast is accepted, then the grant appears 1 cycle later.
- Response arrives with the tag FIFO empty → s_rsp_tready=1, beat dropped, orphan_rsp=1 for exactly 1 cycle.
- Reset asserted mid-packet (beat 2 of 4) → next cycle grant=0, all tready=0, pointer=N_PORTS-1. With AXIS_IIC_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a stalled granted port releases after 16 cycles and timeout_pulse fires.
